uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter: serialises 8-bit bytes onto a single TX line, format 8N1, LSB first, at 50 MHz / CLKS_PER_BIT baud.
- Counterpart of the board's existing uart_rx; drives the DE0 TX pin to return processed pixel data and status to the host PC.
- Single-entry holding register, so a new byte can be queued while the current frame is on the wire. Frames are sent back-to-back with no idle gap.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 4 to 65535

Ports:
i_Clock  in  1  system clock, 50 MHz
i_Reset  in  1  asynchronous reset, active-low
i_Tx_DV  in  1  byte-valid strobe; a byte is accepted when i_Tx_DV=1 and o_Tx_Ready=1 on the same rising edge
i_Tx_Byte  in  8  byte to transmit; sampled only on acceptance
o_Tx_Ready  out  1  holding register empty; can accept a byte this cycle
o_Tx_Active  out  1  high while a frame (start through stop) is on the line
o_Tx_Serial  out  1  serial line; idles high
o_Tx_Done  out  1  one-cycle pulse on the last clock of each stop bit

Behaviour:
- Reset (async assert, sync-safe deassert by design):
  - FSM = IDLE; holding register empty.
  - o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0.
  - Bit counter and clock counter = 0.
- Asserting reset mid-frame aborts the frame immediately: line goes high and any queued byte is discarded.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if holding register full, load shift register, empty holding register, go to START on the next edge. A byte accepted in IDLE starts a frame with o_Tx_Serial low exactly 2 cycles after the accepting edge (1 cycle to hold, 1 to load).
  - START: o_Tx_Serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_Tx_Serial=shift[bit index], each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles. o_Tx_Done=1 on the final cycle. Next state is START if the holding register is full (load it on the same edge, no idle gap), otherwise IDLE.
- Clock counter runs 0..CLKS_PER_BIT-1; width = $clog2(CLKS_PER_BIT). Bit index is 3 bits and wraps only via the state change, never by overflow.
- o_Tx_Active=1 in START, DATA and STOP, including back-to-back transitions.
- Frame length is exactly 10*CLKS_PER_BIT cycles (11* with parity).
- o_Tx_Ready = holding register empty.
  - i_Tx_DV while not ready is ignored (the byte is dropped, not queued).
  - Simultaneous accept and hold-to-shift transfer on the same edge: transfer wins first, so the register ends up holding the new byte.
- i_Tx_Byte changes after acceptance do not affect the frame in flight.

Optional Feature:
- UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bits.
- Undefined: no PARITY state, 8N1 only, and no parity logic is synthesised.

Decomposition:
- Shared include uart_defs.vh holds:
  - FSM state encodings (2-bit; 3-bit when parity is enabled)
  - default CLKS_PER_BIT
  - the IDLE line level constant
  - This file is also used by uart_rx.
- One natural sub-module: uart_baud_cnt. It holds the counter with a clear input and emits a one-cycle tick at CLKS_PER_BIT-1. It is reusable by uart_rx.

Test Plan:
- Reset-values check: with CLKS_PER_BIT=8, hold i_Reset=0 for 5 cycles → o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0 throughout.
- Single byte: CLKS_PER_BIT=8, send 0xA5 → line low at accept+2, then bits 1,0,1,0,0,1,0,1 (LSB first) at 8 cycles each, then stop high. o_Tx_Done pulses once, 80 cycles after the start edge.
- Back-to-back: accept 0x55, then accept 0x0F while o_Tx_Ready=1 mid-frame → the second start bit immediately follows the first stop bit with no high gap. o_Tx_Active stays 1 for 160 cycles; two o_Tx_Done pulses.
- Overrun: with the holding register full, strobe 0xFF → ignored; only the two earlier bytes appear on the line.
- Reset mid-frame: assert i_Reset during DATA bit 3 → o_Tx_Serial=1 within the same cycle (async). After release, a new byte 0x00 transmits a full correct frame.
- Parity build (UART_TX_PARITY_EN): send 0x07 → parity bit 1; send 0x03 → parity bit 0. Each frame is 88 cycles at CLKS_PER_BIT=8.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default bit period and idle line level.
// Also intended for use by uart_rx.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data bits).
package uart_tx_pkg;

  // 50 MHz / 9600 baud
  localparam int unsigned CLKS_PER_BIT_DEF = 5208;

  // Level of the serial line between frames and during the stop bit
  localparam logic LINE_IDLE = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StParity = 3'd4
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-side signals of the UART transmitter.
// Signal names are given from the transmitter's point of view.
interface uart_tx_if;

  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;

  // Byte producer (host logic or testbench)
  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Tx_Active,
    input  o_Tx_Serial,
    input  o_Tx_Done
  );

  // Transmitter
  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Tx_Active,
    output o_Tx_Serial,
    output o_Tx_Done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick on the last count.
// i_Clear holds the counter at zero (used while the line is idle). Shared with uart_rx.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_cnt;

  assign o_Tick = (r_cnt == LastCnt) && !i_Clear;

  // Counter wraps through the tick, so it never overflows its width
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_cnt <= '0;
    end else if (i_Clear || o_Tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first, with a single-entry holding register so the next byte can be
// queued while a frame is on the wire; queued frames follow with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
// Line outputs are registered, so the start bit appears two cycles after the accepting edge.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  uart_tx_if.slave    tx_if
);

  tx_state_e  r_state;
  tx_state_e  w_state_d;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_d;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic       r_serial;
  logic       r_active;
  logic       r_done;
  logic       w_serial_d;
  logic       w_active_d;
  logic       w_done_d;
  logic       w_load;
  logic       w_accept;
  logic       w_tick;
  logic       w_clear;

  assign w_accept = tx_if.i_Tx_DV && !r_hold_full;
  assign w_clear  = (r_state == StIdle);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Clear (w_clear),
    .o_Tick  (w_tick)
  );

  // Next state, bit index and next line outputs from the current state
  always_comb begin
    w_state_d   = r_state;
    w_bit_idx_d = r_bit_idx;
    w_load      = 1'b0;
    w_serial_d  = LINE_IDLE;
    w_active_d  = 1'b1;
    w_done_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_active_d = 1'b0;
        if (r_hold_full) begin
          w_load    = 1'b1;
          w_state_d = StStart;
        end
      end
      StStart: begin
        w_serial_d = 1'b0;
        if (w_tick) begin
          w_state_d   = StData;
          w_bit_idx_d = 3'd0;
        end
      end
      StData: begin
        w_serial_d = r_shift[r_bit_idx];
        if (w_tick) begin
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_state_d   = StParity;
`else
            w_state_d   = StStop;
`endif
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        w_serial_d = even_parity(r_shift);
        if (w_tick) begin
          w_state_d = StStop;
        end
      end
`endif
      StStop: begin
        w_serial_d = LINE_IDLE;
        if (w_tick) begin
          w_done_d = 1'b1;
          // A queued byte starts its frame on the very next cycle
          if (r_hold_full) begin
            w_load    = 1'b1;
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state and bit index
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state   <= StIdle;
      r_bit_idx <= 3'd0;
    end else begin
      r_state   <= w_state_d;
      r_bit_idx <= w_bit_idx_d;
    end
  end

  // Holding register: emptied by the transfer to the shifter, then filled by an accept
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_hold_full <= 1'b0;
      r_hold      <= 8'h00;
    end else begin
      if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold      <= tx_if.i_Tx_Byte;
      end
    end
  end

  // Shift register holds the byte in flight, isolated from later input changes
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_shift <= 8'h00;
    end else if (w_load) begin
      r_shift <= r_hold;
    end
  end

  // Registered line outputs; reset forces the line idle immediately
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_serial <= LINE_IDLE;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_serial <= w_serial_d;
      r_active <= w_active_d;
      r_done   <= w_done_d;
    end
  end

  assign tx_if.o_Tx_Ready  = !r_hold_full;
  assign tx_if.o_Tx_Active = r_active;
  assign tx_if.o_Tx_Serial = r_serial;
  assign tx_if.o_Tx_Done   = r_done;

endmodule
